// File: rtl/ritc_vcdl_phase_scanner.sv
// Purpose : RITC VCDL fan-out with an automatic IDELAY tap scan of the VCDL loopback.
//           The scan reports the first tap where the majority-sampled feedback level flips.
// Latency : VCDL/vcdl_debug_o are 1 cycle after sync_i. delay_o/load_delay_o are registered,
//           so a load command appears on the cycle after it is accepted.
// Backpressure: none. Commands that arrive while they cannot be serviced are dropped.
//           This covers start or manual load while busy, and abort while idle.
//           A scan stalls in SAMPLE for as long as sync_i is absent.
// Ports:
//   CLK, rst_n_i            clock, asynchronous active-low reset
//   sync_i, en_i            sync strobe and per-channel enables
//   VCDL, vcdl_debug_o      registered VCDL pads and the fabric copy that feeds the IDELAY
//   vcdl_fb_i               delayed loopback returned by the IDELAY
//   delay_o, load_delay_o   IDELAY CNTVALUEIN and LD
//   manual_delay_i/load_i   manual tap load, accepted only while idle
//   scan_start_i/abort_i    scan control inputs
//   scan_busy_o/done_o      scan status outputs
//   scan_found_o/tap_o      result of the last scan
module ritc_vcdl_phase_scanner #(
  parameter int NCH       = 1,
  parameter int TAP_BITS  = 5,
  parameter int SAMP_BITS = 6,
  parameter int SETTLE    = 8,
  parameter int FB_LAT    = 2
) (
  input  logic                CLK,
  input  logic                rst_n_i,
  input  logic                sync_i,
  input  logic [NCH-1:0]      en_i,
  output logic [NCH-1:0]      VCDL,
  output logic                vcdl_debug_o,
  input  logic                vcdl_fb_i,
  output logic [TAP_BITS-1:0] delay_o,
  output logic                load_delay_o,
  input  logic [TAP_BITS-1:0] manual_delay_i,
  input  logic                manual_load_i,
  input  logic                scan_start_i,
  input  logic                scan_abort_i,
  output logic                scan_busy_o,
  output logic                scan_done_o,
  output logic                scan_found_o,
  output logic [TAP_BITS-1:0] scan_tap_o
);

  localparam int CW = SAMP_BITS + 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]       NSAMP_LAST  = CW'((2 ** SAMP_BITS) - 1);
  localparam logic [CW-1:0]       HALF        = CW'(2 ** (SAMP_BITS - 1));
  localparam logic [SW-1:0]       SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [TAP_BITS-1:0] TAP_MAX     = {TAP_BITS{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [NCH-1:0]      vcdl_q, vcdl_d;
  logic                dbg_q, dbg_d;
  logic [FB_LAT-1:0]   sync_sr_q, sync_sr_d;
  logic [TAP_BITS-1:0] delay_q, delay_d;
  logic                load_q, load_d;
  logic                done_q, done_d;
  logic                found_q, found_d;
  logic [TAP_BITS-1:0] scan_tap_q, scan_tap_d;
  logic [TAP_BITS-1:0] saved_q, saved_d;
  logic [TAP_BITS-1:0] tap_q, tap_d;
  logic                prev_q, prev_d;
  logic [CW-1:0]       ones_q, ones_d;
  logic [CW-1:0]       nsamp_q, nsamp_d;
  logic [SW-1:0]       settle_q, settle_d;

  logic strobe;
  logic hi;
  logic go_load;
  logic go_done;

  // The feedback arrives FB_LAT cycles after the sync strobe. This shift register marks that cycle.
  assign strobe = sync_sr_q[FB_LAT-1];
  // Majority decision over the tap's samples. An exact tie counts as high.
  assign hi     = (ones_q >= HALF);

  // Pass-through path. It is independent of the scan FSM.
  always_comb begin
    vcdl_d    = {NCH{sync_i}} & en_i;
    dbg_d     = sync_i & (|en_i);
    sync_sr_d = (sync_sr_q << 1) | FB_LAT'(sync_i);
  end

  // Scan FSM: next state and all registered scan outputs.
  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    load_d     = 1'b0;
    done_d     = 1'b0;
    found_d    = found_q;
    scan_tap_d = scan_tap_q;
    saved_d    = saved_q;
    tap_d      = tap_q;
    prev_d     = prev_q;
    ones_d     = ones_q;
    nsamp_d    = nsamp_q;
    settle_d   = settle_q;
    go_load    = 1'b0;
    go_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (scan_start_i) begin
          // Remember the operating tap so that a failed or aborted scan can restore it.
          saved_d    = delay_q;
          found_d    = 1'b0;
          scan_tap_d = '0;
          ones_d     = '0;
          tap_d      = '0;
          go_load    = 1'b1;
        end else if (manual_load_i) begin
          delay_d = manual_delay_i;
          load_d  = 1'b1;
        end
      end
      S_LOAD: begin
        ones_d   = '0;
        nsamp_d  = '0;
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        // Strobes seen here fall inside the IDELAY settling window, so they are ignored.
        if (settle_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_SAMPLE: begin
        if (strobe) begin
          nsamp_d = nsamp_q + CW'(1);
          ones_d  = ones_q + CW'(vcdl_fb_i);
          if (nsamp_q == NSAMP_LAST) begin
            state_d = S_EVAL;
          end
        end
      end
      S_EVAL: begin
        if (tap_q == '0) begin
          prev_d  = hi;
          tap_d   = tap_q + TAP_BITS'(1);
          go_load = 1'b1;
        end else if (hi != prev_q) begin
          found_d    = 1'b1;
          scan_tap_d = tap_q;
          go_done    = 1'b1;
        end else begin
          prev_d = hi;
          // Termination is tested before the increment, so tap never wraps.
          if (tap_q == TAP_MAX) begin
            go_done = 1'b1;
          end else begin
            tap_d   = tap_q + TAP_BITS'(1);
            go_load = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An abort overrides whatever EVAL decided in the same cycle.
    if (scan_abort_i && (state_q inside {S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL})) begin
      found_d    = 1'b0;
      scan_tap_d = scan_tap_q;
      tap_d      = tap_q;
      prev_d     = prev_q;
      go_load    = 1'b0;
      go_done    = 1'b1;
    end

    // The load and done outputs are registered on entry. They are high during the LOAD and DONE cycles.
    if (go_load) begin
      state_d = S_LOAD;
      delay_d = tap_d;
      load_d  = 1'b1;
    end
    if (go_done) begin
      state_d = S_DONE;
      delay_d = found_d ? scan_tap_d : saved_q;
      load_d  = 1'b1;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      vcdl_q     <= '0;
      dbg_q      <= 1'b0;
      sync_sr_q  <= '0;
      delay_q    <= '0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      scan_tap_q <= '0;
      saved_q    <= '0;
      tap_q      <= '0;
      prev_q     <= 1'b0;
      ones_q     <= '0;
      nsamp_q    <= '0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      vcdl_q     <= vcdl_d;
      dbg_q      <= dbg_d;
      sync_sr_q  <= sync_sr_d;
      delay_q    <= delay_d;
      load_q     <= load_d;
      done_q     <= done_d;
      found_q    <= found_d;
      scan_tap_q <= scan_tap_d;
      saved_q    <= saved_d;
      tap_q      <= tap_d;
      prev_q     <= prev_d;
      ones_q     <= ones_d;
      nsamp_q    <= nsamp_d;
      settle_q   <= settle_d;
    end
  end

  assign VCDL         = vcdl_q;
  assign vcdl_debug_o = dbg_q;
  assign delay_o      = delay_q;
  assign load_delay_o = load_q;
  assign scan_busy_o  = (state_q != S_IDLE);
  assign scan_done_o  = done_q;
  assign scan_found_o = found_q;
  assign scan_tap_o   = scan_tap_q;

endmodule

// File: tb/tb_ritc_vcdl_phase_scanner.sv
module tb_ritc_vcdl_phase_scanner;

  localparam int NCH = 2;
  localparam int TB  = 5;
  localparam int SB  = 5;
  localparam int ST  = 8;
  localparam int FL  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sync_gen = 1'b0;
  logic          sync_man = 1'b0;
  logic          sync_i;
  logic [NCH-1:0] en_i = '0;
  logic [NCH-1:0] vcdl;
  logic          vcdl_debug_o;
  logic          vcdl_fb_i;
  logic [TB-1:0] delay_o;
  logic          load_delay_o;
  logic [TB-1:0] manual_delay_i = '0;
  logic          manual_load_i = 1'b0;
  logic          scan_start_i = 1'b0;
  logic          scan_abort_i = 1'b0;
  logic          scan_busy_o;
  logic          scan_done_o;
  logic          scan_found_o;
  logic [TB-1:0] scan_tap_o;

  int total = 0;
  int bad   = 0;

  // Feedback environment
  bit        sync_run = 1'b0;
  bit        alt      = 1'b0;
  int        phase    = 0;
  int        fb_mode  = 0;
  bit [31:0] lvl_v    = '0;

  always #5 clk = ~clk;

  assign sync_i = sync_gen | sync_man;
  // mode 0: level per tap; mode 1: 0 below tap 3, alternating per sync from tap 3 on
  assign vcdl_fb_i = (fb_mode == 1) ? ((delay_o >= 3) ? alt : 1'b0) : lvl_v[delay_o];

  ritc_vcdl_phase_scanner #(
    .NCH(NCH), .TAP_BITS(TB), .SAMP_BITS(SB), .SETTLE(ST), .FB_LAT(FL)
  ) dut (
    .CLK(clk), .rst_n_i(rst_n), .sync_i(sync_i), .en_i(en_i), .VCDL(vcdl),
    .vcdl_debug_o(vcdl_debug_o), .vcdl_fb_i(vcdl_fb_i), .delay_o(delay_o),
    .load_delay_o(load_delay_o), .manual_delay_i(manual_delay_i),
    .manual_load_i(manual_load_i), .scan_start_i(scan_start_i),
    .scan_abort_i(scan_abort_i), .scan_busy_o(scan_busy_o), .scan_done_o(scan_done_o),
    .scan_found_o(scan_found_o), .scan_tap_o(scan_tap_o)
  );

  // Sync generator: one pulse every 8 cycles while enabled; alt toggles at each pulse.
  initial forever begin
    @(posedge clk); #1;
    if (sync_run) begin
      sync_gen = (phase == 0);
      if (phase == 0) alt = ~alt;
      phase = (phase + 1) % 8;
    end else begin
      sync_gen = 1'b0;
      phase    = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference model: per-tap majority level hv; the first flip at tap t>0 ends the scan.
  function automatic void model(input bit [31:0] hv, input int prior,
                                output bit f, output int tap, output int nloads, output int fin);
    f = 0; tap = 0; nloads = 32; fin = prior;
    for (int t = 1; t < 32; t++) begin
      if (hv[t] != hv[t-1]) begin
        f = 1; tap = t; nloads = t + 1; fin = t;
        break;
      end
    end
  endfunction

  task automatic manual_load(input int v);
    manual_delay_i = TB'(v);
    manual_load_i  = 1'b1;
    tick();
    manual_load_i  = 1'b0;
  endtask

  task automatic run_scan(input string nm, input bit [31:0] hv, input int mode, input int prior);
    bit ef; int et, enl, efin;
    int nl, c, fin, tp;
    bit seq_ok, got_done, fnd, fl;
    model(hv, prior, ef, et, enl, efin);
    lvl_v   = hv;
    fb_mode = mode;
    manual_load(prior);
    scan_start_i = 1'b1;
    tick();
    scan_start_i = 1'b0;
    nl = 0; c = 0; seq_ok = 1; got_done = 0; fin = 0; tp = 0; fnd = 0; fl = 0;
    while (!got_done && c < 15000) begin
      if (scan_done_o) begin
        got_done = 1; fin = delay_o; fnd = scan_found_o; tp = scan_tap_o; fl = load_delay_o;
      end else if (load_delay_o) begin
        if (delay_o != TB'(nl)) seq_ok = 0;
        nl++;
      end
      if (!got_done) begin tick(); c++; end
    end
    chk({nm, " done_seen"}, got_done, 1);
    chk({nm, " load_count"}, nl, enl);
    chk({nm, " load_taps_in_order"}, seq_ok, 1);
    chk({nm, " found"}, fnd, ef);
    chk({nm, " tap"}, tp, ef ? et : 0);
    chk({nm, " final_delay"}, fin, efin);
    chk({nm, " final_load"}, fl, 1);
    tick();
    chk({nm, " busy_after"}, scan_busy_o, 0);
    chk({nm, " done_single"}, scan_done_o, 0);
    chk({nm, " found_held"}, scan_found_o, ef);
    chk({nm, " delay_held"}, delay_o, efin);
  endtask

  typedef struct {
    logic [1:0] en;
    logic       sync;
    logic [1:0] exp_v;
    logic       exp_d;
  } pt_vec_t;

  initial begin
    pt_vec_t   vec[8];
    bit [31:0] hv;
    bit [31:0] all1;
    int        c;
    bit        seen;

    vec[0] = '{2'b00, 1'b0, 2'b00, 1'b0};
    vec[1] = '{2'b00, 1'b1, 2'b00, 1'b0};
    vec[2] = '{2'b01, 1'b1, 2'b01, 1'b1};
    vec[3] = '{2'b01, 1'b0, 2'b00, 1'b0};
    vec[4] = '{2'b10, 1'b1, 2'b10, 1'b1};
    vec[5] = '{2'b11, 1'b1, 2'b11, 1'b1};
    vec[6] = '{2'b11, 1'b0, 2'b00, 1'b0};
    vec[7] = '{2'b10, 1'b0, 2'b00, 1'b0};

    // Reset state, with active inputs that must not leak through while reset is held.
    en_i = 2'b01; sync_man = 1'b1;
    repeat (3) tick();
    chk("rst VCDL", vcdl, 0);
    chk("rst debug", vcdl_debug_o, 0);
    chk("rst delay", delay_o, 0);
    chk("rst load", load_delay_o, 0);
    chk("rst busy", scan_busy_o, 0);
    chk("rst done", scan_done_o, 0);
    chk("rst found", scan_found_o, 0);
    chk("rst tap", scan_tap_o, 0);
    sync_man = 1'b0;
    rst_n = 1'b1;
    tick();

    // Pass-through table
    for (int i = 0; i < 8; i++) begin
      en_i = vec[i].en; sync_man = vec[i].sync;
      tick();
      chk($sformatf("pt%0d VCDL", i), vcdl, vec[i].exp_v);
      chk($sformatf("pt%0d debug", i), vcdl_debug_o, vec[i].exp_d);
    end
    sync_man = 1'b0; en_i = 2'b01;
    tick();

    // Manual load
    manual_delay_i = 5'd17; manual_load_i = 1'b1;
    tick();
    manual_load_i = 1'b0;
    chk("man delay", delay_o, 17);
    chk("man load", load_delay_o, 1);
    tick();
    chk("man load_single", load_delay_o, 0);
    chk("man delay_held", delay_o, 17);

    // Abort while idle is ignored
    scan_abort_i = 1'b1;
    tick();
    scan_abort_i = 1'b0;
    chk("idle_abort done", scan_done_o, 0);
    chk("idle_abort busy", scan_busy_o, 0);
    chk("idle_abort load", load_delay_o, 0);

    sync_run = 1'b1;
    all1 = '1;
    run_scan("edge12", all1 << 12, 0, 5);
    run_scan("noedge", all1, 0, 7);
    run_scan("tie", all1 << 3, 1, 22);
    for (int r = 0; r < 3; r++) begin
      int e;
      bit pol;
      e   = $urandom_range(0, 31);
      pol = 1'($urandom % 2);
      hv  = (all1 << e) ^ {32{pol}};
      run_scan($sformatf("rnd%0d", r), hv, 0, $urandom_range(0, 31));
    end

    // Abort during tap 4 SAMPLE; a start while busy is ignored as well
    lvl_v = '0; fb_mode = 0;
    manual_load(9);
    scan_start_i = 1'b1; tick(); scan_start_i = 1'b0;
    c = 0;
    while (!(load_delay_o && delay_o == 4) && c < 5000) begin tick(); c++; end
    chk("abort reached_tap4", (load_delay_o && delay_o == 4), 1);
    repeat (40) tick();
    scan_start_i = 1'b1; tick(); scan_start_i = 1'b0;
    chk("busy_start ignored", load_delay_o, 0);
    scan_abort_i = 1'b1; tick(); scan_abort_i = 1'b0;
    chk("abort done", scan_done_o, 1);
    chk("abort found", scan_found_o, 0);
    chk("abort delay_restored", delay_o, 9);
    chk("abort load", load_delay_o, 1);
    chk("abort busy_in_done", scan_busy_o, 1);
    tick();
    chk("abort busy_drop", scan_busy_o, 0);
    chk("abort done_single", scan_done_o, 0);

    // Start and manual load in the same cycle: the scan wins
    manual_load(20);
    scan_start_i = 1'b1; manual_load_i = 1'b1; manual_delay_i = 5'd3;
    tick();
    scan_start_i = 1'b0; manual_load_i = 1'b0;
    chk("start_man busy", scan_busy_o, 1);
    chk("start_man delay_tap0", delay_o, 0);
    chk("start_man load", load_delay_o, 1);
    tick();
    scan_abort_i = 1'b1; tick(); scan_abort_i = 1'b0;
    chk("start_man restored", delay_o, 20);
    tick();

    // Sync stopped: stays in SAMPLE; manual load ignored while busy
    sync_run = 1'b0;
    repeat (4) tick();
    scan_start_i = 1'b1; tick(); scan_start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (scan_done_o) seen = 1;
    end
    chk("stall busy", scan_busy_o, 1);
    chk("stall no_done", seen, 0);
    manual_delay_i = 5'd30; manual_load_i = 1'b1; tick(); manual_load_i = 1'b0;
    chk("busy_man load", load_delay_o, 0);
    chk("busy_man delay", delay_o, 0);
    scan_abort_i = 1'b1; tick(); scan_abort_i = 1'b0;
    chk("stall abort_done", scan_done_o, 1);
    tick();

    // Async reset mid-SETTLE of tap 1
    sync_run = 1'b1; lvl_v = '0; fb_mode = 0;
    scan_start_i = 1'b1; tick(); scan_start_i = 1'b0;
    c = 0;
    while (!(load_delay_o && delay_o == 1) && c < 2000) begin tick(); c++; end
    chk("rst_mid reached_tap1", (load_delay_o && delay_o == 1), 1);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid busy", scan_busy_o, 0);
    chk("rst_mid load", load_delay_o, 0);
    chk("rst_mid delay", delay_o, 0);
    chk("rst_mid done", scan_done_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_mid still_idle", scan_busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
